latency_timer: RTL

- Parametrised frame round-trip latency timer for the delay tester, clocked in the tx_clk domain.
- Timestamps each frame_sent pulse into an in-order FIFO of outstanding frames. Each frame_caught pulse retires the oldest entry and reports its latency.
- Maintains min, max, sample and lost-frame statistics, with timeout-based loss detection.
- Sits between the TX frame generator (frame_sent) and the RX frame matcher (frame_caught). Results go to the host register/readout logic.

---
 rtl/latency_timer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/latency_timer.sv
// latency_timer
//    Frame round-trip latency timer in the tx_clk domain. Every frame_sent
//    pulse stores the current free-running time into an in-order FIFO; every
//    frame_caught pulse retires the oldest entry and reports how long it was
//    outstanding. Entries older than TIMEOUT are retired as lost frames.
//
// Ports
//    reset          asynchronous active-high reset
//    tx_clk         clock
//    clear          synchronous clear of statistics and sticky flags
//    frame_sent     pulse: a frame left TX (push timestamp)
//    frame_caught   pulse: a frame returned on RX (pop and measure)
//    time_dif_out   latency of the most recent caught frame
//    time_dif_valid one-cycle pulse when time_dif_out updates
//    min_dif        minimum latency since reset/clear (all ones when none)
//    max_dif        maximum latency since reset/clear
//    sample_count   caught frames measured, saturating
//    lost_count     frames retired by timeout, saturating
//    outstanding    FIFO occupancy after the current edge
//    overflow       sticky: frame_sent dropped because the FIFO was full
//    orphan         sticky: frame_caught arrived with the FIFO empty
module latency_timer #(
   parameter int CNT_W   = 20,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 1000,
   parameter int STAT_W  = 16
) (
   input  logic                     reset,
   input  logic                     tx_clk,
   input  logic                     clear,
   input  logic                     frame_sent,
   input  logic                     frame_caught,
   output logic [CNT_W-1:0]         time_dif_out,
   output logic                     time_dif_valid,
   output logic [CNT_W-1:0]         min_dif,
   output logic [CNT_W-1:0]         max_dif,
   output logic [STAT_W-1:0]        sample_count,
   output logic [STAT_W-1:0]        lost_count,
   output logic [$clog2(DEPTH):0]   outstanding,
   output logic                     overflow,
   output logic                     orphan
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONES  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [AW:0]       PTR_ONE   = (AW+1)'(1);
   localparam logic [AW:0]       PTR_ZERO  = {(AW+1){1'b0}};
   localparam logic [STAT_W-1:0] STAT_ONE  = STAT_W'(1);
   localparam logic [STAT_W-1:0] STAT_ONES = {STAT_W{1'b1}};
   localparam logic [STAT_W-1:0] STAT_ZERO = {STAT_W{1'b0}};

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] mem_r [DEPTH];
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic [AW:0]      wr_ptr_nxt_s;
   logic [AW:0]      rd_ptr_nxt_s;

   logic             empty_s;
   logic             full_s;
   logic [CNT_W-1:0] head_s;
   logic [CNT_W-1:0] age_s;
   logic             catch_pop_s;
   logic             timeout_pop_s;
   logic             pop_s;
   logic             push_s;

   // FIFO status, head age and the push/pop decisions for this cycle
   always_comb begin
      empty_s = (wr_ptr_r == rd_ptr_r);
      // Extra pointer MSB differs only when the write side has lapped the read side.
      full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
      head_s  = mem_r[rd_ptr_r[AW-1:0]];
      // Modular difference stays correct across counter wrap.
      age_s   = cnt_r - head_s;
      catch_pop_s   = frame_caught && !empty_s;
      // A catch wins over a timeout, so only an uncaught head can expire.
      timeout_pop_s = !frame_caught && !empty_s && (age_s >= TIMEOUT_C);
      pop_s         = catch_pop_s || timeout_pop_s;
      // A same-cycle pop frees the slot, so a push into a full FIFO is legal then.
      push_s        = frame_sent && (!full_s || pop_s);
      if (push_s) begin
         wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
         wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
         rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end
   end

   // Free-running time counter, FIFO pointers and registered occupancy
   always_ff @(posedge tx_clk or posedge reset) begin
      if (reset) begin
         cnt_r       <= CNT_ZERO;
         wr_ptr_r    <= PTR_ZERO;
         rd_ptr_r    <= PTR_ZERO;
         outstanding <= PTR_ZERO;
      end else begin
         cnt_r       <= cnt_r + CNT_ONE;
         wr_ptr_r    <= wr_ptr_nxt_s;
         rd_ptr_r    <= rd_ptr_nxt_s;
         outstanding <= wr_ptr_nxt_s - rd_ptr_nxt_s;
      end
   end

   // Timestamp storage; contents are only meaningful between the pointers
   always_ff @(posedge tx_clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= cnt_r;
      end
   end

   // Latest measured latency and its one-cycle valid pulse (not touched by clear)
   always_ff @(posedge tx_clk or posedge reset) begin
      if (reset) begin
         time_dif_out   <= CNT_ZERO;
         time_dif_valid <= 1'b0;
      end else begin
         time_dif_valid <= catch_pop_s;
         if (catch_pop_s) begin
            time_dif_out <= age_s;
         end
      end
   end

   // Min/max/sample/lost statistics; clear overrides same-cycle updates
   always_ff @(posedge tx_clk or posedge reset) begin
      if (reset) begin
         min_dif      <= CNT_ONES;
         max_dif      <= CNT_ZERO;
         sample_count <= STAT_ZERO;
         lost_count   <= STAT_ZERO;
      end else if (clear) begin
         min_dif      <= CNT_ONES;
         max_dif      <= CNT_ZERO;
         sample_count <= STAT_ZERO;
         lost_count   <= STAT_ZERO;
      end else begin
         if (catch_pop_s) begin
            if (age_s < min_dif) begin
               min_dif <= age_s;
            end
            if (age_s > max_dif) begin
               max_dif <= age_s;
            end
            if (sample_count != STAT_ONES) begin
               sample_count <= sample_count + STAT_ONE;
            end
         end
         if (timeout_pop_s && (lost_count != STAT_ONES)) begin
            lost_count <= lost_count + STAT_ONE;
         end
      end
   end

   // Sticky error flags; the empty check for orphan uses pre-push state
   always_ff @(posedge tx_clk or posedge reset) begin
      if (reset) begin
         overflow <= 1'b0;
         orphan   <= 1'b0;
      end else if (clear) begin
         overflow <= 1'b0;
         orphan   <= 1'b0;
      end else begin
         if (frame_sent && full_s && !pop_s) begin
            overflow <= 1'b1;
         end
         if (frame_caught && empty_s) begin
            orphan <= 1'b1;
         end
      end
   end

endmodule
